// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with EX-stage operand forwarding and
//            load-use hazard detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_dest,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_shamt,
    input  logic [3:0]  in_alu_op,
    input  logic        in_alu_src,
    input  logic        in_reg_write,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_dest,
    input  logic [31:0] exmem_value,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_dest,
    input  logic [31:0] memwb_value,
    output logic [31:0] first,
    output logic [31:0] second,
    output logic [3:0]  op,
    output logic [4:0]  shamt,
    output logic [31:0] store_data,
    output logic [4:0]  dest,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        valid,
    output logic        load_use
);

    localparam logic [4:0] c_REG_ZERO = 5'd0;
    localparam logic [3:0] c_OP_NOP   = 4'b0000;

    logic        r_valid;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_dest;
    logic [31:0] r_rs_val;
    logic [31:0] r_rt_val;
    logic [31:0] r_imm;
    logic [4:0]  r_shamt;
    logic [3:0]  r_op;
    logic        r_alu_src;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;

    logic        w_rs_hit_exmem;
    logic        w_rs_hit_memwb;
    logic        w_rt_hit_exmem;
    logic        w_rt_hit_memwb;
    logic [31:0] w_fwd_rs;
    logic [31:0] w_fwd_rt;
    logic        w_dest_match;

    // Register 0 is hardwired, so a write to it must never be forwarded.
    assign w_rs_hit_exmem = exmem_reg_write && (exmem_dest == r_rs) && (r_rs != c_REG_ZERO);
    assign w_rs_hit_memwb = memwb_reg_write && (memwb_dest == r_rs) && (r_rs != c_REG_ZERO);
    assign w_rt_hit_exmem = exmem_reg_write && (exmem_dest == r_rt) && (r_rt != c_REG_ZERO);
    assign w_rt_hit_memwb = memwb_reg_write && (memwb_dest == r_rt) && (r_rt != c_REG_ZERO);

    // EX/MEM holds the younger result and therefore wins over MEM/WB.
    always_comb begin
        w_fwd_rs = r_rs_val;
        if (w_rs_hit_exmem) begin
            w_fwd_rs = exmem_value;
        end else if (w_rs_hit_memwb) begin
            w_fwd_rs = memwb_value;
        end
    end

    always_comb begin
        w_fwd_rt = r_rt_val;
        if (w_rt_hit_exmem) begin
            w_fwd_rt = exmem_value;
        end else if (w_rt_hit_memwb) begin
            w_fwd_rt = memwb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && !in_valid)) begin
            r_valid     <= 1'b0;
            r_rs        <= c_REG_ZERO;
            r_rt        <= c_REG_ZERO;
            r_dest      <= c_REG_ZERO;
            r_rs_val    <= 32'd0;
            r_rt_val    <= 32'd0;
            r_imm       <= 32'd0;
            r_shamt     <= 5'd0;
            r_op        <= c_OP_NOP;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (stall) begin
            // Latch forwarded operands so they survive MEM/WB retiring.
            r_rs_val <= w_fwd_rs;
            r_rt_val <= w_fwd_rt;
        end else begin
            r_valid     <= 1'b1;
            r_rs        <= in_rs;
            r_rt        <= in_rt;
            r_dest      <= in_dest;
            r_rs_val    <= in_rs_val;
            r_rt_val    <= in_rt_val;
            r_imm       <= in_imm;
            r_shamt     <= in_shamt;
            r_op        <= in_alu_op;
            r_alu_src   <= in_alu_src;
            r_reg_write <= in_reg_write;
            r_mem_read  <= in_mem_read;
            r_mem_write <= in_mem_write;
        end
    end

    assign first      = w_fwd_rs;
    assign second     = r_alu_src ? r_imm : w_fwd_rt;
    assign store_data = w_fwd_rt;
    assign op         = r_op;
    assign shamt      = r_shamt;
    assign dest       = r_dest;
    assign valid      = r_valid;
    assign reg_write  = r_reg_write && r_valid;
    assign mem_read   = r_mem_read  && r_valid;
    assign mem_write  = r_mem_write && r_valid;

    assign w_dest_match = (r_dest == in_rs) || (r_dest == in_rt);
    assign load_use     = r_valid && r_mem_read && (r_dest != c_REG_ZERO)
                          && in_valid && w_dest_match;

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decode-stage instruction present
- stall  in  1  hold EX contents (downstream not ready)
- flush  in  1  replace EX contents with bubble
- in_rs, in_rt, in_dest  in  5 each  source and destination register numbers
- in_rs_val, in_rt_val  in  32 each  register-file read data
- in_imm  in  32  sign-extended immediate
- in_shamt  in  5  shift amount
- in_alu_op  in  4  ALU control code
- in_alu_src  in  1  1 = second operand is immediate
- in_reg_write, in_mem_read, in_mem_write  in  1 each  control bits
- exmem_reg_write  in  1; exmem_dest  in  5; exmem_value  in  32  EX/MEM forward source
- memwb_reg_write  in  1; memwb_dest  in  5; memwb_value  in  32  MEM/WB forward source
- first, second  out  32 each  ALU operands
- op  out  4  ALU control
- shamt  out  5  ALU shift amount
- store_data  out  32  forwarded rt value for stores
- dest  out  5  destination register
- reg_write, mem_read, mem_write  out  1 each  registered control bits, gated by valid
- valid  out  1  EX slot holds a real instruction
- load_use  out  1  stall request to decode

Function
REQ-003 Each rising edge SHALL update the EX register according to the highest-priority applicable case: rst > flush > stall > in_valid=0 > load.
REQ-004 A load (in_valid=1, no flush or stall) SHALL capture all in_* fields and set valid=1.
REQ-005 A bubble (flush=1, or in_valid=0 with stall=0) SHALL clear valid, reg_write, mem_read, mem_write, dest, and op (op=4'b0000); data fields are don't-care but SHALL be zeroed.
REQ-006 A stall (stall=1, flush=0) SHALL hold every field, except the stored rs/rt values, which SHALL be overwritten with the currently forwarded values so that forwarded data is not lost as MEM/WB retires.
REQ-007 Forwarded rs value: exmem_value if exmem_reg_write=1, exmem_dest=rs_q and rs_q≠0; otherwise memwb_value under the same test on memwb; otherwise rs_val_q.
REQ-008 Forwarded rt value SHALL follow the same rule using rt_q.
REQ-009 EX/MEM SHALL take priority over MEM/WB when both match.
REQ-010 Register 0 SHALL never be forwarded and SHALL read as the stored value.
REQ-011 first SHALL equal the forwarded rs value.
REQ-012 second SHALL equal imm_q when alu_src_q=1, else the forwarded rt value.
REQ-013 store_data SHALL always equal the forwarded rt value.
REQ-014 Operand outputs SHALL be combinational from the registered fields and the forward inputs, with zero added latency.
REQ-015 reg_write, mem_read, and mem_write outputs SHALL be the registered bits ANDed with valid.
REQ-016 load_use SHALL be asserted combinationally when valid=1, mem_read=1, dest≠0, in_valid=1, and (dest=in_rs or dest=in_rt).
REQ-017 The block SHALL NOT self-stall; decode owns the stall and injects a bubble via in_valid=0.
REQ-018 All comparisons SHALL be exact 5-bit compares, and all data paths SHALL be 32 bits with no sign manipulation inside the block.

Reset
REQ-019 On a rst-sampled edge, all registered fields SHALL clear to 0, giving valid=0, op=0000, first=second=store_data=0 (absent forwarding), dest=0, control outputs 0, and load_use=0.
REQ-020 Reset mid-stall or mid-flush SHALL override both.
REQ-021 The first non-reset edge SHALL load normally.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Load add: rs=3, rs_val=5, rt=4, rt_val=7, op=0010, alu_src=0 -> next cycle first=5, second=7, op=0010, valid=1.
- Double forward: rs_q=3 with exmem(dest=3, val=0xAAAA, wr=1) and memwb(dest=3, val=0xBBBB, wr=1) -> first=0xAAAA; with exmem wr=0 -> first=0xBBBB.
- R0 guard: rs_q=0 with exmem dest=0, wr=1, val=0x1234 -> first=stored value (0).
- Stall capture: stall=1 while memwb forwards 0x55 to rt_q; next edge memwb changes -> second still 0x55; all other fields are unchanged.
- Load-use: EX holds lw with dest=8, decode in_rs=8 -> load_use=1; bubble loaded next edge -> valid=0, load_use=0.
- Flush plus stall simultaneously -> bubble (valid=0, reg_write=0); rst asserted with stall=1 -> all outputs 0 next cycle.
